// File: rtl/pipe_defs.sv
// Shared definitions for the ID/EX stage and its forwarding helper.
//   - ALU function codes carried on IdFunct / Signal
//   - default datapath and register-number widths
//   - EX-slot control bundle and its bubble value
package pipe_defs;

  localparam int WIDTH_DEF = 32;
  localparam int RADDR_DEF = 5;

  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SRL = 6'b000010;

  typedef struct packed {
    logic valid;
    logic alusrc;
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
  } ctrl_t;

  // A bubble is an invalid slot with every control bit cleared.
  localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/forward_unit.sv
// Operand source select for one ALU source register.
// Picks the EX/MEM result, then the MEM/WB result, then the value latched
// in ID/EX. Register 0 is never forwarded because it is hard-wired to zero.
// Ports:
//   i_src                      source register number held in ID/EX
//   i_latched                  register-file value latched in ID/EX
//   i_mem_regwrite/rd/result   EX/MEM producer
//   i_wb_regwrite/rd/result    MEM/WB producer
//   o_data                     selected operand
module forward_unit
  import pipe_defs::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int RADDR = RADDR_DEF
) (
  input  logic [RADDR-1:0] i_src,
  input  logic [WIDTH-1:0] i_latched,
  input  logic             i_mem_regwrite,
  input  logic [RADDR-1:0] i_mem_rd,
  input  logic [WIDTH-1:0] i_mem_result,
  input  logic             i_wb_regwrite,
  input  logic [RADDR-1:0] i_wb_rd,
  input  logic [WIDTH-1:0] i_wb_result,
  output logic [WIDTH-1:0] o_data
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = i_mem_regwrite & (i_mem_rd != '0) & (i_mem_rd == i_src);
  assign w_wb_hit  = i_wb_regwrite  & (i_wb_rd  != '0) & (i_wb_rd  == i_src);

  // The younger producer (MEM) wins over the older one (WB).
  always_comb begin
    o_data = i_latched;
    if (w_mem_hit) begin
      o_data = i_mem_result;
    end else if (w_wb_hit) begin
      o_data = i_wb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and ALU operand select.
// Latches the decoded instruction, drives the ALU operands and the EX-side
// control towards EX/MEM, and raises Stall to freeze PC and IF/ID while a
// bubble is inserted into EX.
//
// Build option FORWARD_EN:
//   defined   - operands are forwarded from EX/MEM and MEM/WB; Stall only
//               on a load-use hazard.
//   undefined - no forwarding; Stall on any RAW hazard against EX or MEM.
//
// Ports:
//   clk, Reset (sync, active-high), Hold (freeze), Flush (discard ID)
//   Id*                 decoded instruction from ID
//   Mem*, Wb*           producers in EX/MEM and MEM/WB
//   Stall               hold PC and IF/ID
//   DataA, DataB        ALU operands; Signal ALU function code
//   ExValid, ExDest, ExStoreData, ExRegWrite, ExMemRead, ExMemWrite,
//   ExMemToReg          EX-side outputs for EX/MEM
module id_ex_stage
  import pipe_defs::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int RADDR = RADDR_DEF
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Hold,
  input  logic             Flush,
  input  logic             IdValid,
  input  logic [WIDTH-1:0] IdRsData,
  input  logic [WIDTH-1:0] IdRtData,
  input  logic [WIDTH-1:0] IdImm,
  input  logic [4:0]       IdShamt,
  input  logic [5:0]       IdFunct,
  input  logic [RADDR-1:0] IdRs,
  input  logic [RADDR-1:0] IdRt,
  input  logic [RADDR-1:0] IdRd,
  input  logic             IdRegDst,
  input  logic             IdALUSrc,
  input  logic             IdRegWrite,
  input  logic             IdMemRead,
  input  logic             IdMemWrite,
  input  logic             IdMemToReg,
  input  logic             MemRegWrite,
  input  logic [RADDR-1:0] MemRd,
  input  logic [WIDTH-1:0] MemResult,
  input  logic             WbRegWrite,
  input  logic [RADDR-1:0] WbRd,
  input  logic [WIDTH-1:0] WbResult,
  output logic             Stall,
  output logic [WIDTH-1:0] DataA,
  output logic [WIDTH-1:0] DataB,
  output logic [5:0]       Signal,
  output logic             ExValid,
  output logic [RADDR-1:0] ExDest,
  output logic [WIDTH-1:0] ExStoreData,
  output logic             ExRegWrite,
  output logic             ExMemRead,
  output logic             ExMemWrite,
  output logic             ExMemToReg
);

  ctrl_t            r_ctrl_p1;
  logic [5:0]       r_funct_p1;
  logic [4:0]       r_shamt_p1;
  logic [RADDR-1:0] r_rs_p1;
  logic [RADDR-1:0] r_rt_p1;
  logic [RADDR-1:0] r_dest_p1;
  logic [WIDTH-1:0] r_rsdata_p1;
  logic [WIDTH-1:0] r_rtdata_p1;
  logic [WIDTH-1:0] r_imm_p1;

  logic             w_stall;
  logic [WIDTH-1:0] w_fwd_rs;
  logic [WIDTH-1:0] w_fwd_rt;

`ifdef FORWARD_EN
  // Only a load in EX cannot be forwarded in time; everything else is
  // picked up by the forwarding muxes.
  assign w_stall = r_ctrl_p1.valid & r_ctrl_p1.memread & (r_dest_p1 != '0) &
                   IdValid & ((r_dest_p1 == IdRs) | (r_dest_p1 == IdRt));

  forward_unit #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_rs (
    .i_src          (r_rs_p1),
    .i_latched      (r_rsdata_p1),
    .i_mem_regwrite (MemRegWrite),
    .i_mem_rd       (MemRd),
    .i_mem_result   (MemResult),
    .i_wb_regwrite  (WbRegWrite),
    .i_wb_rd        (WbRd),
    .i_wb_result    (WbResult),
    .o_data         (w_fwd_rs)
  );

  forward_unit #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_rt (
    .i_src          (r_rt_p1),
    .i_latched      (r_rtdata_p1),
    .i_mem_regwrite (MemRegWrite),
    .i_mem_rd       (MemRd),
    .i_mem_result   (MemResult),
    .i_wb_regwrite  (WbRegWrite),
    .i_wb_rd        (WbRd),
    .i_wb_result    (WbResult),
    .o_data         (w_fwd_rt)
  );
`else
  logic w_ex_writes;
  logic w_rs_hit;
  logic w_rt_hit;
  logic w_unused;

  // Without forwarding the ID instruction waits until every producer has
  // left EX and MEM; WB is covered by the write-through register file.
  assign w_ex_writes = r_ctrl_p1.valid & r_ctrl_p1.regwrite;
  assign w_rs_hit = (IdRs != '0) &
                    ((w_ex_writes & (r_dest_p1 == IdRs)) | (MemRegWrite & (MemRd == IdRs)));
  assign w_rt_hit = (IdRt != '0) &
                    ((w_ex_writes & (r_dest_p1 == IdRt)) | (MemRegWrite & (MemRd == IdRt)));
  assign w_stall  = w_rs_hit | w_rt_hit;

  assign w_fwd_rs = r_rsdata_p1;
  assign w_fwd_rt = r_rtdata_p1;

  // Forwarding data is not consumed in this build.
  assign w_unused = ^{MemResult, WbRegWrite, WbRd, WbResult};
`endif

  // ---- ID -> EX boundary ----
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_ctrl_p1   <= BUBBLE_CTRL;
      r_funct_p1  <= '0;
      r_shamt_p1  <= '0;
      r_rs_p1     <= '0;
      r_rt_p1     <= '0;
      r_dest_p1   <= '0;
      r_rsdata_p1 <= '0;
      r_rtdata_p1 <= '0;
      r_imm_p1    <= '0;
    end else if (!Hold) begin
      if (Flush || w_stall) begin
        r_ctrl_p1   <= BUBBLE_CTRL;
        r_funct_p1  <= '0;
        r_shamt_p1  <= '0;
        r_rs_p1     <= '0;
        r_rt_p1     <= '0;
        r_dest_p1   <= '0;
        r_rsdata_p1 <= '0;
        r_rtdata_p1 <= '0;
        r_imm_p1    <= '0;
      end else begin
        r_ctrl_p1   <= '{valid:    IdValid,
                         alusrc:   IdALUSrc,
                         regwrite: IdRegWrite,
                         memread:  IdMemRead,
                         memwrite: IdMemWrite,
                         memtoreg: IdMemToReg};
        r_funct_p1  <= IdFunct;
        r_shamt_p1  <= IdShamt;
        r_rs_p1     <= IdRs;
        r_rt_p1     <= IdRt;
        r_dest_p1   <= IdRegDst ? IdRd : IdRt;
        r_rsdata_p1 <= IdRsData;
        r_rtdata_p1 <= IdRtData;
        r_imm_p1    <= IdImm;
      end
    end
  end

  // ---- EX-side operand select ----
  assign Stall       = w_stall & ~Reset;
  assign Signal      = r_funct_p1;
  assign DataA       = (r_funct_p1 == FN_SRL) ? {{(WIDTH-5){1'b0}}, r_shamt_p1} : w_fwd_rs;
  assign DataB       = r_ctrl_p1.alusrc ? r_imm_p1 : w_fwd_rt;
  assign ExStoreData = w_fwd_rt;
  assign ExValid     = r_ctrl_p1.valid;
  assign ExDest      = r_dest_p1;
  assign ExRegWrite  = r_ctrl_p1.regwrite;
  assign ExMemRead   = r_ctrl_p1.memread;
  assign ExMemWrite  = r_ctrl_p1.memwrite;
  assign ExMemToReg  = r_ctrl_p1.memtoreg;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register and operand-select stage that feeds the 32-bit ALU. It latches the decoded instruction from ID and forwards results from EX/MEM and MEM/WB onto the ALU inputs. It detects load-use hazards, stalling IF/ID and inserting a bubble. Downstream, the EX/MEM register consumes the ALU result together with this block's EX-side outputs.

Parameters:
WIDTH, 32, datapath width
RADDR, 5, register-number width

Ports:
clk  in  1  clock, rising edge
Reset  in  1  synchronous active-high reset
Hold  in  1  global pipeline freeze (memory wait); register keeps contents
Flush  in  1  taken branch/jump; the ID instruction is discarded
IdValid  in  1  ID slot holds a real instruction
IdRsData, IdRtData  in  WIDTH  register-file read data
IdImm  in  WIDTH  sign-extended immediate
IdShamt  in  5  shift amount
IdFunct  in  6  ALU function code (AND/OR/ADD/SUB/SLT/SRL encoding)
IdRs, IdRt, IdRd  in  RADDR  source and destination register numbers
IdRegDst, IdALUSrc, IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg  in  1  control bits
MemRegWrite  in  1  EX/MEM instruction writes a register
MemRd  in  RADDR  EX/MEM destination register
MemResult  in  WIDTH  EX/MEM ALU result
WbRegWrite  in  1  MEM/WB instruction writes a register
WbRd  in  RADDR  MEM/WB destination register
WbResult  in  WIDTH  MEM/WB write-back data
Stall  out  1  to PC and IF/ID: hold the current instruction
DataA, DataB  out  WIDTH  ALU operands
Signal  out  6  ALU function code
ExValid  out  1  EX slot holds a real instruction
ExDest  out  RADDR  write register (IdRd if RegDst, else IdRt)
ExStoreData  out  WIDTH  forwarded rt value, used for stores
ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg  out  1  registered control bits

Behaviour:
- Reset: all registered state is 0. ExValid=0, all control bits=0, Signal=0, ExDest=0, latched data=0. DataA and DataB then read 0, because there is no forwarding match with register 0.
- Register-update priority each edge: Reset > Hold (keep contents) > Flush (load bubble) > Stall (load bubble) > normal load of the Id* inputs, with ExValid=IdValid.
- Bubble: ExValid=0 and every control bit=0. Data fields are don't-care, but RTL must load 0.
- Flush asserted during Hold is ignored. Upstream keeps Flush asserted until Hold drops.
- Stall (combinational):
  - Condition: ExValid & ExMemRead & ExDest!=0 & IdValid & (ExDest==IdRs | ExDest==IdRt).
  - Stall is independent of Hold and Flush, and is 0 during Reset.
- Forwarding (combinational on the latched Rs/Rt):
  - Select MemResult if MemRegWrite & MemRd!=0 & MemRd==src.
  - Otherwise select WbResult if WbRegWrite & WbRd!=0 & WbRd==src.
  - Otherwise use the latched data.
  - MEM has priority over WB. Register 0 is never forwarded.
- Operand select:
  - DataA = {27'b0, shamt} when Signal==SRL; otherwise the forwarded rs value.
  - DataB = latched Imm when ALUSrc=1; otherwise the forwarded rt value.
  - ExStoreData is always the forwarded rt value.
- Latency: ID inputs appear on the outputs one cycle after the edge. Forwarded values pass through in the same cycle.
- A load-use pair costs exactly one bubble. On the next cycle the load is in MEM and the value comes from MEM/WB.
- Reset in the middle of a stall clears EX. Stall deasserts because ExValid=0.
- A same-cycle register-file write and read in ID is resolved by the write-through register file and is not handled here.

Optional Feature:
FORWARD_EN
- Defined: forwarding as above. Stall only on load-use.
- Undefined: no forwarding; DataA and DataB use the latched values directly.
  - Stall widens to any RAW hazard: IdRs or IdRt (non-zero) matches either ExDest with ExRegWrite & ExValid, or MemRd with MemRegWrite.
  - Each stalled cycle inserts one bubble.

Decomposition:
- Shared package/header pipe_defs:
  - Funct constants: AND 6'b100100, OR 6'b100101, ADD 6'b100000, SUB 6'b100010, SLT 6'b101010, SRL 6'b000010.
  - WIDTH and RADDR defaults.
  - Bubble control constant.
- One sub-module, forward_unit: purely combinational source-select for rs and rt, instantiated twice.

Test Plan:
- Reset: Reset=1 for 2 cycles with random Id* inputs -> ExValid=0, all control bits 0, Signal=0, Stall=0. Release -> an ADD (rs=2, data 5; rt=3, data 7) gives DataA=5, DataB=7 and Signal=6'b100000 after 1 cycle.
- Forward priority: EX holds rs=4, latched data 1. MemRd=4, MemResult=0x10; WbRd=4, WbResult=0x20 -> DataA=0x10. Drop MemRegWrite -> DataA=0x20. Set MemRd=0 -> not forwarded.
- Load-use: lw $8 in EX, then add with rs=8 in ID -> Stall=1 for exactly 1 cycle and the next EX is a bubble. The add then gets DataA from WbResult.
- Flush/Hold: Flush=1 -> next ExValid=0. Hold=1 together with Flush=1 -> contents unchanged; after Hold drops and Flush is still asserted, EX holds a bubble.
- SRL/ALUSrc: SRL with shamt=3, rt data 0x80 -> DataA=3, DataB=0x80. An ALUSrc instruction with IdImm=0xFFFFFFFC -> DataB=0xFFFFFFFC.
- FORWARD_EN undefined: the EX/MEM RAW case above -> Stall=1 until the producer leaves MEM, and DataA equals the latched register value.
